// File: rtl/axi_hs_fifo.sv
// axi_hs_fifo: synchronous valid/ready FIFO with first-word fall-through.
// Full and empty are told apart by a wrap bit per pointer. The pointers wrap
// explicitly at DEPTH-1, so DEPTH does not need to be a power of two.
// Writes while full and reads while empty are dropped, and each one sets a
// sticky error flag. Only reset or flush clears those flags.
module axi_hs_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         ovf_err,
  output logic                         udf_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_wrap_q, wr_wrap_d;
  logic          rd_wrap_q, rd_wrap_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic full, empty, push, pop;

  // Status is derived from registered pointers only, never from the handshake inputs.
  always_comb begin
    full  = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q != rd_wrap_q);
    empty = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q == rd_wrap_q);
    push  = s_valid && !full;
    pop   = m_ready && !empty;
  end

  assign s_ready      = !full;
  assign m_valid      = !empty;
  assign m_data       = mem_q[rd_ptr_q];
  assign count        = count_q;
  assign almost_full  = (int'(count_q) >= AFULL_THRESH);
  assign almost_empty = (int'(count_q) <= AEMPTY_THRESH);
  assign ovf_err      = ovf_q;
  assign udf_err      = udf_q;

  // Next-state: pointer advance with explicit wrap, occupancy, sticky errors; flush wins.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_wrap_d = wr_wrap_q;
    rd_ptr_d  = rd_ptr_q;
    rd_wrap_d = rd_wrap_q;
    count_d   = count_q;
    ovf_d     = ovf_q | (s_valid & full);
    udf_d     = udf_q | (m_ready & empty);

    if (push) begin
      if (wr_ptr_q == LAST) begin
        wr_ptr_d  = '0;
        wr_wrap_d = !wr_wrap_q;
      end else begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end

    if (pop) begin
      if (rd_ptr_q == LAST) begin
        rd_ptr_d  = '0;
        rd_wrap_d = !rd_wrap_q;
      end else begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d  = '0;
      wr_wrap_d = 1'b0;
      rd_ptr_d  = '0;
      rd_wrap_d = 1'b0;
      count_d   = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end
  end

  // Control state register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_ptr_q  <= '0;
      rd_wrap_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_wrap_q <= wr_wrap_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_wrap_q <= rd_wrap_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage write. It has no reset, and a write under flush is harmless
  // because the pointers are cleared in the same cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_axi_hs_fifo.sv
// Bench for axi_hs_fifo. It runs two instances side by side (DEPTH=16 and
// DEPTH=5) on the same stimulus. Each instance is compared every cycle against
// a queue-based reference model.
module tb_axi_hs_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] s_data = 8'h00;

  logic       a_s_ready, a_m_valid, a_af, a_ae, a_ovf, a_udf;
  logic [7:0] a_m_data;
  logic [4:0] a_count;
  logic       b_s_ready, b_m_valid, b_af, b_ae, b_ovf, b_udf;
  logic [7:0] b_m_data;
  logic [2:0] b_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic       ov0 = 1'b0, ud0 = 1'b0, ov1 = 1'b0, ud1 = 1'b0;
  logic [7:0] hist[$];

  axi_hs_fifo #(.DATA_WIDTH(8), .DEPTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
    .count(a_count), .almost_full(a_af), .almost_empty(a_ae),
    .ovf_err(a_ovf), .udf_err(a_udf)
  );

  axi_hs_fifo #(.DATA_WIDTH(8), .DEPTH(5)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
    .count(b_count), .almost_full(b_af), .almost_empty(b_ae),
    .ovf_err(b_ovf), .udf_err(b_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input string nm, input int dep, input int sz, input logic [7:0] head,
                           input logic ov, input logic ud, input logic sr, input logic mv,
                           input logic [7:0] md, input logic [31:0] cnt, input logic af,
                           input logic ae, input logic eo, input logic eu);
    chk({nm, "_count"}, cnt, 32'(sz));
    chk({nm, "_s_ready"}, 32'(sr), 32'(sz < dep));
    chk({nm, "_m_valid"}, 32'(mv), 32'(sz > 0));
    if (sz > 0) chk({nm, "_m_data"}, 32'(md), 32'(head));
    chk({nm, "_almost_full"}, 32'(af), 32'(sz >= dep - 2));
    chk({nm, "_almost_empty"}, 32'(ae), 32'(sz <= 1));
    chk({nm, "_ovf_err"}, 32'(eo), 32'(ov));
    chk({nm, "_udf_err"}, 32'(eu), 32'(ud));
  endtask

  task automatic check_all();
    check_dut("A", 16, mq0.size(), (mq0.size() > 0) ? mq0[0] : 8'h00, ov0, ud0,
              a_s_ready, a_m_valid, a_m_data, 32'(a_count), a_af, a_ae, a_ovf, a_udf);
    check_dut("B", 5, mq1.size(), (mq1.size() > 0) ? mq1[0] : 8'h00, ov1, ud1,
              b_s_ready, b_m_valid, b_m_data, 32'(b_count), b_af, b_ae, b_ovf, b_udf);
  endtask

  task automatic model_clear();
    mq0.delete(); mq1.delete();
    ov0 = 1'b0; ud0 = 1'b0; ov1 = 1'b0; ud1 = 1'b0;
  endtask

  task automatic model_edge(input logic sv, input logic [7:0] d, input logic mr, input logic fl);
    bit p, q;
    if (fl) begin
      model_clear();
    end else begin
      p = sv && (mq0.size() < 16);
      q = mr && (mq0.size() > 0);
      if (sv && mq0.size() == 16) ov0 = 1'b1;
      if (mr && mq0.size() == 0)  ud0 = 1'b1;
      if (q) void'(mq0.pop_front());
      if (p) mq0.push_back(d);
      p = sv && (mq1.size() < 5);
      q = mr && (mq1.size() > 0);
      if (sv && mq1.size() == 5) ov1 = 1'b1;
      if (mr && mq1.size() == 0) ud1 = 1'b1;
      if (q) void'(mq1.pop_front());
      if (p) mq1.push_back(d);
    end
  endtask

  task automatic step(input logic sv, input logic [7:0] d, input logic mr, input logic fl);
    s_valid = sv; s_data = d; m_ready = mr; flush = fl;
    #1 check_all();
    @(posedge clk);
    model_edge(sv, d, mr, fl);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    // reset state
    #1 check_all();
    chk("rst_a_s_ready", 32'(a_s_ready), 32'd1);
    chk("rst_a_almost_empty", 32'(a_ae), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // DEPTH=16 fill then drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_af", 32'(a_af), 32'(i + 1 >= 14));
    end
    chk("fill_count16", 32'(a_count), 32'd16);
    chk("fill_s_ready0", 32'(a_s_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(a_m_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_m_valid0", 32'(a_m_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // DEPTH=5 wrap with interleaved push/pop
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'h40 + 8'(i), (i >= 3) && (i % 2 == 1), 1'b0);
      chk("wrap_b_cnt_le5", 32'(b_count <= 3'd5), 32'd1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // steady state at count=8: output lags input by 8
    hist.delete();
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      hist.push_back(v);
      step(1'b1, v, 1'b0, 1'b0);
    end
    for (int j = 0; j < 20; j++) begin
      v = 8'($urandom);
      hist.push_back(v);
      chk("lag_m_data", 32'(a_m_data), 32'(hist[j]));
      step(1'b1, v, 1'b1, 1'b0);
      chk("lag_count8", 32'(a_count), 32'd8);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // overflow / underflow sticky flags, cleared by flush
    for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(a_ovf), 32'd1);
    chk("ovf_head_kept", 32'(a_m_data), 32'h80);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", 32'(a_udf), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_ovf0", 32'(a_ovf), 32'd0);
    chk("flush_udf0", 32'(a_udf), 32'd0);
    chk("flush_count0", 32'(a_count), 32'd0);

    // flush beats a concurrent push
    for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("flushpush_count0", 32'(a_count), 32'd0);
    chk("flushpush_m_valid0", 32'(a_m_valid), 32'd0);

    // asynchronous reset mid-cycle at count=7
    for (int i = 0; i < 7; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    s_valid = 1'b0; m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count0", 32'(a_count), 32'd0);
    chk("arst_m_valid0", 32'(a_m_valid), 32'd0);
    chk("arst_s_ready1", 32'(a_s_ready), 32'd1);
    model_clear();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // random traffic, push-biased then pop-biased, occasional flush
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0) ^ (i >= 200 && $urandom_range(0, 1) == 1),
           8'($urandom),
           (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 60) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
